// File: rtl/ring_meter_pkg.sv
// Shared types and sizing helpers for the ring oscillator frequency meter.
package ring_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } meter_state_t;

    localparam int DEF_GATE_CYCLES   = 1024;
    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_CNT_W         = 16;

    // Timer must hold the larger of the two reload values (count - 1).
    function automatic int timer_width(input int gate_cycles, input int settle_cycles);
        int m;
        m = (gate_cycles > settle_cycles) ? gate_cycles : settle_cycles;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/ring_osc_freq_meter_sync.sv
// Multi-stage synchronizer for an asynchronous level with a one-cycle rise pulse.
module sync_rise_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) sync_reg[gi] <= 1'b0;
                    else        sync_reg[gi] <= async_i;
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) sync_reg[gi] <= 1'b0;
                    else        sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_reg <= 1'b0;
        else        prev_reg <= sync_reg[SYNC_STAGES-1];
    end

    // Both terms come from flops in this domain, so the pulse is clean.
    assign rise_o = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/ring_osc_freq_meter.sv
// Enables a ring oscillator, waits for it to settle, then counts its rising
// edges over a fixed gate window and reports the (saturating) count.
module ring_osc_freq_meter
    import ring_meter_pkg::*;
#(
    parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    output logic             osc_en_o,
    input  logic             osc_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] count_o,
    output logic             ovf_o
);

    localparam int TW = timer_width(GATE_CYCLES, SETTLE_CYCLES);
    localparam logic [TW-1:0]    SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0]    GATE_LOAD   = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    meter_state_t     state_reg;
    logic [TW-1:0]    timer_reg;
    logic [CNT_W-1:0] edge_cnt_reg;
    logic [CNT_W-1:0] edge_cnt_next;
    logic             ovf_flag_reg;
    logic             ovf_flag_next;
    logic             rise;

    sync_rise_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .async_i(osc_i),
        .rise_o (rise)
    );

    // Saturating count; an edge arriving at full scale only raises the flag.
    always_comb begin
        edge_cnt_next = edge_cnt_reg;
        ovf_flag_next = ovf_flag_reg;
        if (rise) begin
            if (edge_cnt_reg == CNT_MAX) ovf_flag_next = 1'b1;
            else                         edge_cnt_next = edge_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            edge_cnt_reg <= '0;
            ovf_flag_reg <= 1'b0;
            osc_en_o     <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            count_o      <= '0;
            ovf_o        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        state_reg <= SETTLE;
                        timer_reg <= SETTLE_LOAD;
                        osc_en_o  <= 1'b1;
                        busy_o    <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (timer_reg == '0) begin
                        state_reg    <= MEASURE;
                        timer_reg    <= GATE_LOAD;
                        edge_cnt_reg <= '0;
                        ovf_flag_reg <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg - TW'(1);
                    end
                end
                MEASURE: begin
                    edge_cnt_reg <= edge_cnt_next;
                    ovf_flag_reg <= ovf_flag_next;
                    if (timer_reg == '0) begin
                        // Use the next values so an edge in the final gate cycle counts.
                        state_reg <= DONE;
                        osc_en_o  <= 1'b0;
                        done_o    <= 1'b1;
                        count_o   <= edge_cnt_next;
                        ovf_o     <= ovf_flag_next;
                    end else begin
                        timer_reg <= timer_reg - TW'(1);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_o    <= 1'b0;
                    busy_o    <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Directed bench: table of oscillator patterns with expected count ranges,
// plus hand-written lockout, retrigger and mid-measurement reset sequences.
module tb_ring_osc_freq_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        osc_i = 1'b0;
    logic        osc_en_o, busy_o, done_o, ovf_o;
    logic [15:0] count_o;
    logic        s_osc_en, s_busy, s_done, s_ovf;
    logic [3:0]  s_count;

    int checks = 0;
    int errors = 0;

    // Oscillator model: half period in clk cycles, 0 means hold osc_level.
    int   osc_half = 0;
    logic osc_level = 1'b0;
    int   osc_ph = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (osc_half > 0) begin
            osc_ph = osc_ph + 1;
            if (osc_ph >= osc_half) begin
                osc_ph = 0;
                osc_i  = ~osc_i;
            end
        end else begin
            osc_ph = 0;
            osc_i  = osc_level;
        end
    end

    ring_osc_freq_meter #(
        .GATE_CYCLES(1024), .SETTLE_CYCLES(16), .CNT_W(16), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .osc_en_o(osc_en_o),
        .osc_i(osc_i), .busy_o(busy_o), .done_o(done_o), .count_o(count_o), .ovf_o(ovf_o)
    );

    ring_osc_freq_meter #(
        .GATE_CYCLES(1024), .SETTLE_CYCLES(16), .CNT_W(4), .SYNC_STAGES(2)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .osc_en_o(s_osc_en),
        .osc_i(osc_i), .busy_o(s_busy), .done_o(s_done), .count_o(s_count), .ovf_o(s_ovf)
    );

    task automatic chk(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Pulse start, then follow the run until done_o (bounded).
    task automatic run_meas(output int lat, output int en_cycles);
        int n;
        @(negedge clk) start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
        n = 1;
        en_cycles = 0;
        while (!done_o && n < 3000) begin
            if (osc_en_o) en_cycles++;
            @(negedge clk);
            n++;
        end
        lat = n;
    endtask

    typedef struct {
        int   half;
        logic level;
        int   lo;
        int   hi;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int lat, en, dones, slo, shi;

        vecs[0] = '{half: 4, level: 1'b0, lo: 127, hi: 129};
        vecs[1] = '{half: 0, level: 1'b0, lo: 0,   hi: 0};
        vecs[2] = '{half: 0, level: 1'b1, lo: 0,   hi: 0};
        vecs[3] = '{half: 2, level: 1'b0, lo: 255, hi: 257};
        vecs[4] = '{half: 0, level: 1'b0, lo: 0,   hi: 0};
        vecs[5] = '{half: 3, level: 1'b0, lo: 170, hi: 172};
        vecs[6] = '{half: 5, level: 1'b0, lo: 101, hi: 104};

        repeat (3) @(negedge clk);
        chk("rst_osc_en", int'(osc_en_o), 0, 0);
        chk("rst_busy",   int'(busy_o),   0, 0);
        chk("rst_done",   int'(done_o),   0, 0);
        chk("rst_count",  int'(count_o),  0, 0);
        chk("rst_ovf",    int'(ovf_o) + int'(s_ovf), 0, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            osc_half  = vecs[i].half;
            osc_level = vecs[i].level;
            repeat (5) @(negedge clk);
            run_meas(lat, en);
            slo = (vecs[i].lo > 15) ? 15 : vecs[i].lo;
            shi = (vecs[i].hi > 15) ? 15 : vecs[i].hi;
            chk($sformatf("v%0d_latency", i), lat, 1041, 1041);
            chk($sformatf("v%0d_osc_en_cycles", i), en, 1040, 1040);
            chk($sformatf("v%0d_osc_en_in_done", i), int'(osc_en_o), 0, 0);
            chk($sformatf("v%0d_count", i), int'(count_o), vecs[i].lo, vecs[i].hi);
            chk($sformatf("v%0d_ovf", i), int'(ovf_o), 0, 0);
            chk($sformatf("v%0d_sat_count", i), int'(s_count), slo, shi);
            if (vecs[i].lo > 15)
                chk($sformatf("v%0d_sat_ovf", i), int'(s_ovf), 1, 1);
            else
                chk($sformatf("v%0d_sat_ovf", i), int'(s_ovf), 0, 0);
            @(negedge clk);
            chk($sformatf("v%0d_done_width", i), int'(done_o), 0, 0);
            chk($sformatf("v%0d_busy_after", i), int'(busy_o), 0, 0);
            $display("vec %0d half=%0d lvl=%0b latency=%0d count=%0d ovf=%0b sat=%0d/%0b",
                     i, vecs[i].half, vecs[i].level, lat, count_o, ovf_o, s_count, s_ovf);
        end

        // Edges only during SETTLE must not be counted.
        osc_half  = 0;
        osc_level = 1'b0;
        repeat (5) @(negedge clk);
        @(negedge clk) start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            osc_level = (n % 4 == 1) || (n % 4 == 2);
            @(negedge clk);
        end
        osc_level = 1'b0;
        lat = 13;
        while (!done_o && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        chk("settle_excl_latency", lat, 1041, 1041);
        chk("settle_excl_count", int'(count_o), 0, 0);
        $display("settle exclusion: latency=%0d count=%0d", lat, count_o);
        repeat (3) @(negedge clk);

        // Start pulses in SETTLE, MEASURE and DONE yield one result only.
        osc_half = 4;
        dones = 0;
        @(negedge clk) start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
        for (int n = 1; n <= 1100; n++) begin
            start_i = (n == 5) || (n == 500) || done_o;
            if (done_o) dones++;
            @(negedge clk);
        end
        start_i = 1'b0;
        chk("lockout_done_pulses", dones, 1, 1);
        chk("lockout_idle_after", int'(busy_o), 0, 0);
        $display("busy lockout: done pulses=%0d", dones);

        // Held start: one idle cycle after DONE, then a fresh SETTLE.
        start_i = 1'b1;
        lat = 0;
        while (!done_o && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        chk("held_first_done", int'(done_o), 1, 1);
        @(negedge clk);
        chk("held_idle_gap", int'(busy_o), 0, 0);
        @(negedge clk);
        chk("held_retrigger_busy", int'(busy_o), 1, 1);
        chk("held_retrigger_osc_en", int'(osc_en_o), 1, 1);
        start_i = 1'b0;
        lat = 0;
        while (!done_o && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        chk("held_second_done", int'(done_o), 1, 1);
        chk("held_second_count", int'(count_o), 127, 129);
        $display("held start: second count=%0d", count_o);
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of the gate window.
        osc_half = 2;
        @(negedge clk) start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
        for (int n = 1; n < 516; n++) @(negedge clk);
        chk("mid_busy_before_rst", int'(busy_o), 1, 1);
        chk("mid_count_before_rst", int'(count_o), 127, 129);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_osc_en", int'(osc_en_o), 0, 0);
        chk("mid_rst_busy", int'(busy_o), 0, 0);
        chk("mid_rst_count", int'(count_o), 0, 0);
        chk("mid_rst_ovf", int'(ovf_o) + int'(s_ovf), 0, 0);
        @(negedge clk) rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 20; n++) begin
            if (done_o) dones++;
            @(negedge clk);
        end
        chk("mid_rst_no_done", dones, 0, 0);
        osc_half = 4;
        run_meas(lat, en);
        chk("post_rst_latency", lat, 1041, 1041);
        chk("post_rst_count", int'(count_o), 127, 129);
        $display("reset mid-measure: post-reset latency=%0d count=%0d", lat, count_o);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
